counter_cmd_sequencer: RTL and testbench
========================================

COUNTER_CMD_SEQUENCER -- requirements
Module: counter_cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO depth in entries (power of two, 2..8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  2  opcode: 00 NOP, 01 LOAD, 10 UP, 11 DOWN.
REQ-007 cmd_arg  input  5  LOAD value, or UP/DOWN repeat count.
REQ-008 Load  output  1  load strobe to the up/down counter.
REQ-009 IN  output  5  load value to the up/down counter.
REQ-010 UP  output  1  count-up request to the up/down counter.
REQ-011 DOWN  output  1  count-down request to the up/down counter.
REQ-012 busy  output  1  a command is currently being issued.
REQ-013 fifo_count  output  4  number of queued, not yet popped commands (0..DEPTH).

Function
REQ-014 Command accepted at a rising edge when cmd_valid=1 and cmd_ready=1; {cmd_op, cmd_arg} written to FIFO tail.
REQ-015 cmd_ready = (fifo_count < DEPTH), from registered count only; a pop in the same cycle does not raise cmd_ready.
REQ-016 cmd_valid while cmd_ready=0: no write, no state change; the upstream holds the command.
REQ-017 FSM states: IDLE, ISSUE; busy=1 exactly in ISSUE.
REQ-018 IDLE with FIFO non-empty: pop head at next edge.
- LOAD: enter ISSUE, remain 1 cycle.
- UP/DOWN with arg=N>=1: enter ISSUE, remain N cycles.
- NOP, or UP/DOWN with arg=0: discarded, stay IDLE, no strobe.
REQ-019 Load, UP, DOWN, IN are registered; at most one of Load/UP/DOWN is 1 in any cycle.
REQ-020 LOAD in ISSUE: Load=1 and IN=arg for exactly one cycle; IN=0 whenever Load=0.
REQ-021 UP (DOWN) in ISSUE: UP (DOWN)=1 for exactly N consecutive cycles; remaining count held in a 5-bit down-counter, no wrap.
REQ-022 Latency: command accepted at edge E into an empty FIFO in IDLE; strobe first high in the cycle after edge E+1.
REQ-023 Last ISSUE cycle with FIFO non-empty: pop next command at the same edge; its strobe follows with no idle cycle. Discardable heads return to IDLE for one cycle per discarded entry.
REQ-024 Last ISSUE cycle with FIFO empty: go to IDLE, all strobes 0.
REQ-025 Simultaneous push and pop: fifo_count unchanged; order preserved strictly FIFO.
REQ-026 Sequencer does not observe counter saturation; clamping at 0/31 remains the counter's responsibility.

Reset
REQ-027 RST=0 asynchronously forces: FSM IDLE, FIFO empty (fifo_count=0), Load=UP=DOWN=0, IN=0, busy=0, repeat counter 0.
REQ-028 Reset mid-ISSUE aborts the command immediately; queued commands are lost.
REQ-029 No command is accepted while RST=0; after release, the first acceptance is possible at the first rising edge.

Verification
REQ-030 Reset, push LOAD arg=21 -> one cycle later, Load=1 and IN=21 for one cycle; busy=1 for that cycle only.
REQ-031 Push UP arg=3 then DOWN arg=2 back-to-back -> UP high 3 cycles, then DOWN high 2 cycles with no gap.
REQ-032 Hold cmd_valid with 6 UP arg=31 commands, DEPTH=4 -> cmd_ready drops at fifo_count=4; no command lost or duplicated; total UP high cycles = 186.
REQ-033 Push NOP, UP arg=0, LOAD arg=7 -> only Load=1 (IN=7) appears, preceded by 2 discarded-pop cycles with all strobes 0.
REQ-034 Assert RST=0 during the 2nd cycle of DOWN arg=10 with 2 queued commands -> DOWN=0 at once; fifo_count=0; no strobe after release until a new push.
REQ-035 Randomised push/backpressure, 10k cycles -> strobe sequence equals the reference model; Load/UP/DOWN are never high together.

Source files
------------

// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: queues up/down-counter commands in a FIFO and replays them
// as registered Load/UP/DOWN strobes, one command after another with no idle gap.
module counter_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_arg,
  output logic       Load,
  output logic [4:0] IN,
  output logic       UP,
  output logic       DOWN,
  output logic       busy,
  output logic [3:0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_d;
  logic [6:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0] rpt, rpt_d, in_d, harg;
  logic [1:0] hop;
  logic load_d, up_d, down_d, push, pop, live;
  assign cmd_ready = fifo_count < 4'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign {hop, harg} = mem[rd_ptr];
  // NOP and zero-count UP/DOWN are popped but never issued
  assign live = hop == 2'b01 || (hop[1] && harg != 5'd0);
  assign busy = state == ISSUE;
  always_comb begin
    state_d = state;
    rpt_d = rpt;
    load_d = 1'b0;
    in_d = 5'd0;
    up_d = 1'b0;
    down_d = 1'b0;
    pop = 1'b0;
    if (busy && rpt != 5'd0) begin
      rpt_d = rpt - 5'd1;
      up_d = UP;
      down_d = DOWN;
    end else if (fifo_count != 4'd0) begin
      pop = 1'b1;
      state_d = live ? ISSUE : IDLE;
      load_d = hop == 2'b01;
      in_d = hop == 2'b01 ? harg : 5'd0;
      up_d = hop == 2'b10 && live;
      down_d = hop == 2'b11 && live;
      rpt_d = hop[1] && live ? harg - 5'd1 : 5'd0;
    end else begin
      state_d = IDLE;
      rpt_d = 5'd0;
    end
  end
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      rpt <= 5'd0;
      Load <= 1'b0;
      IN <= 5'd0;
      UP <= 1'b0;
      DOWN <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= 4'd0;
    end else begin
      state <= state_d;
      rpt <= rpt_d;
      Load <= load_d;
      IN <= in_d;
      UP <= up_d;
      DOWN <= down_d;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + 4'(push) - 4'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {cmd_op, cmd_arg};
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: table vectors, directed corner sequences and a randomised
// run compared against an expected strobe stream built from accepted commands.
module tb_counter_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int KL = 4, KU = 2, KD = 1;
  logic clk = 0, RST = 0, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [4:0] cmd_arg = 0;
  logic cmd_ready, Load, UP, DOWN, busy;
  logic [4:0] IN;
  logic [3:0] fifo_count;
  int errors = 0, checks = 0;
  int q[$];
  counter_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .Load(Load), .IN(IN), .UP(UP),
    .DOWN(DOWN), .busy(busy), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] op;
    logic [4:0] arg;
    int kind;
    int n;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int strb();
    return int'({Load, UP, DOWN});
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    RST = 0;
    cmd_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1;
  endtask
  task automatic push(input logic [1:0] op, input logic [4:0] arg);
    cmd_valid = 1;
    cmd_op = op;
    cmd_arg = arg;
    tick();
    cmd_valid = 0;
  endtask
  // expected strobe stream: one entry per strobe cycle, kind*32 + IN
  task automatic expand(input logic [1:0] op, input logic [4:0] arg);
    if (op == 2'b01) q.push_back(KL * 32 + int'(arg));
    else if (op[1]) for (int i = 0; i < int'(arg); i++) q.push_back((op == 2'b10 ? KU : KD) * 32);
  endtask
  task automatic step_check();
    int s, bad, e;
    tick();
    s = strb();
    bad = 0;
    if ($countones(s) > 1) bad |= 1;
    if (busy !== (s != 0)) bad |= 2;
    if (!Load && IN != 0) bad |= 4;
    if (cmd_ready !== (fifo_count < DEPTH)) bad |= 8;
    if (fifo_count > DEPTH) bad |= 16;
    chk("rand_invariants", bad, 0);
    if (s != 0) begin
      if (q.size() == 0) chk("rand_unexpected_strobe", s, 0);
      else begin
        e = q.pop_front();
        chk("rand_strobe", s * 32 + int'(IN), e);
      end
    end
  endtask
  initial begin
    int tr[7];
    int expt[7];
    tbl[0] = '{2'b01, 5'd0, KL, 1};
    tbl[1] = '{2'b01, 5'd31, KL, 1};
    tbl[2] = '{2'b01, 5'd21, KL, 1};
    tbl[3] = '{2'b10, 5'd1, KU, 1};
    tbl[4] = '{2'b10, 5'd5, KU, 5};
    tbl[5] = '{2'b11, 5'd1, KD, 1};
    tbl[6] = '{2'b11, 5'd4, KD, 4};
    tbl[7] = '{2'b00, 5'd9, 0, 0};
    tbl[8] = '{2'b10, 5'd0, 0, 0};
    tbl[9] = '{2'b11, 5'd0, 0, 0};
    do_reset();
    #1;
    chk("reset_strobes", strb(), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_ready", int'(cmd_ready), 1);
    // single-command vectors: strobe starts one cycle after acceptance, runs n cycles
    for (int v = 0; v < 10; v++) begin
      int first, last, n, bad;
      first = -1; last = -1; n = 0; bad = 0;
      do_reset();
      push(tbl[v].op, tbl[v].arg);
      for (int c = 0; c < 40; c++) begin
        if (strb() != 0) begin
          if (first < 0) first = c;
          last = c;
          n++;
          if (strb() != tbl[v].kind) bad++;
          if (IN != (tbl[v].kind == KL ? tbl[v].arg : 5'd0)) bad++;
          if (busy !== 1'b1) bad++;
        end else if (busy !== 1'b0 || IN != 0) bad++;
        tick();
      end
      chk($sformatf("vec%0d_cycles", v), n, tbl[v].n);
      chk($sformatf("vec%0d_bad", v), bad, 0);
      if (tbl[v].n > 0) begin
        chk($sformatf("vec%0d_first", v), first, 1);
        chk($sformatf("vec%0d_last", v), last, tbl[v].n);
      end
    end
    // LOAD 21: one cycle of Load with IN=21 and busy
    do_reset();
    push(2'b01, 5'd21);
    chk("load_count_after_push", int'(fifo_count), 1);
    chk("load_idle_strobe", strb(), 0);
    tick();
    chk("load_strobe", strb() * 32 + int'(IN), KL * 32 + 21);
    chk("load_busy", int'(busy), 1);
    tick();
    chk("load_after_strobe", strb() * 32 + int'(IN), 0);
    chk("load_after_busy", int'(busy), 0);
    // UP 3 then DOWN 2 back-to-back, no gap
    do_reset();
    push(2'b10, 5'd3);
    tr[0] = strb();
    push(2'b11, 5'd2);
    tr[1] = strb();
    for (int i = 2; i < 7; i++) begin
      tick();
      tr[i] = strb();
    end
    expt = '{0, KU, KU, KU, KD, KD, 0};
    for (int i = 0; i < 7; i++) chk($sformatf("updown_trace%0d", i), tr[i], expt[i]);
    // NOP, UP 0, LOAD 7: two discarded pops, then a single Load
    do_reset();
    push(2'b00, 5'd3);
    tr[0] = strb() + 8 * int'(busy);
    push(2'b10, 5'd0);
    tr[1] = strb() + 8 * int'(busy);
    push(2'b01, 5'd7);
    tr[2] = strb() + 8 * int'(busy);
    chk("discard_count_push_pop", int'(fifo_count), 1);
    tick();
    tr[3] = strb() + 8 * int'(busy);
    chk("discard_load_in", int'(IN), 7);
    tick();
    tr[4] = strb() + 8 * int'(busy);
    expt = '{0, 0, 0, KL + 8, 0, 0, 0};
    for (int i = 0; i < 5; i++) chk($sformatf("discard_trace%0d", i), tr[i], expt[i]);
    // six UP 31 held at the input: backpressure, none lost or duplicated
    begin
      int pushed, upc, sawfull, ready_bad;
      pushed = 0; upc = 0; sawfull = 0; ready_bad = 0;
      do_reset();
      cmd_op = 2'b10;
      cmd_arg = 5'd31;
      for (int c = 0; c < 400; c++) begin
        cmd_valid = pushed < 6;
        if (cmd_valid && cmd_ready) pushed++;
        tick();
        if (UP) upc++;
        if (fifo_count == DEPTH) begin
          sawfull = 1;
          if (cmd_ready) ready_bad++;
        end
      end
      cmd_valid = 0;
      chk("bp_pushed", pushed, 6);
      chk("bp_up_cycles", upc, 186);
      chk("bp_saw_full", sawfull, 1);
      chk("bp_ready_at_full", ready_bad, 0);
    end
    // reset during second DOWN cycle with two commands queued
    begin
      int bad;
      do_reset();
      push(2'b11, 5'd10);
      push(2'b10, 5'd5);
      push(2'b01, 5'd3);
      chk("rst_mid_down", strb(), KD);
      chk("rst_mid_count", int'(fifo_count), 2);
      RST = 0;
      #1;
      chk("rst_async_strobes", strb() * 32 + int'(IN), 0);
      chk("rst_async_busy", int'(busy), 0);
      chk("rst_async_count", int'(fifo_count), 0);
      cmd_valid = 1;
      cmd_op = 2'b01;
      cmd_arg = 5'd9;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_no_accept", int'(fifo_count), 0);
      cmd_valid = 0;
      @(negedge clk);
      RST = 1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (strb() != 0 || busy || fifo_count != 0) bad++;
      end
      chk("rst_quiet_after", bad, 0);
    end
    // randomised traffic with backpressure against the expected strobe stream
    do_reset();
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      if (!(cmd_valid && !cmd_ready)) begin
        cmd_valid = $urandom_range(0, 99) < 60;
        cmd_op = 2'($urandom);
        cmd_arg = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 6));
      end
      if (cmd_valid && cmd_ready) expand(cmd_op, cmd_arg);
      step_check();
    end
    cmd_valid = 0;
    for (int c = 0; c < 400; c++) step_check();
    chk("rand_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
